tile_param_cfg_streamer: RTL and testbench
==========================================

// Module: tile_param_cfg_streamer
//
// PURPOSE
//  Upstream config stage for a 2-D tile grid. On start it walks a 2-D parameter
//  array [0:N_Y_P-1][0:N_X_P-1] in row-major order, one entry per (y,x) tile.
//  Each entry goes out as a config word over a valid/ready handshake to the
//  per-tile config sinks.
//  Reports busy/done, a transfer count and an XOR checksum so the grid can
//  confirm it received the whole load.
//
// PARAMETERS
//  N_X_P        4            columns per row (>=1)
//  N_Y_P        4            rows (>=1)
//  DATA_W_P     32           config word width; entries truncated to this width
//  SKIP_ZERO_P  0            1: entries equal to 0 are skipped, never presented
//  TWODIM_P     all 0        integer [0:N_Y_P-1][0:N_X_P-1]; per-tile config value
//
// PORTS
//  clk          in   1        single clock, rising edge
//  reset        in   1        synchronous, active-high
//  start_i      in   1        begin a scan; honoured only in IDLE
//  busy_o       out  1        high from cycle after accepted start until DONE
//  done_o       out  1        one-cycle pulse when scan complete
//  cfg_v_o      out  1        config word valid
//  cfg_ready_i  in   1        sink accepts word this cycle
//  cfg_y_o      out  Y_W      row of current word, Y_W = max(1,$clog2(N_Y_P))
//  cfg_x_o      out  X_W      column of current word, X_W = max(1,$clog2(N_X_P))
//  cfg_data_o   out  DATA_W_P TWODIM_P[cfg_y_o][cfg_x_o]
//  count_o      out  CNT_W    words transferred this scan, CNT_W=$clog2(N_X_P*N_Y_P+1)
//  checksum_o   out  DATA_W_P XOR of all transferred words this scan
//
// BEHAVIOUR
//  Reset: state IDLE, busy_o=0, done_o=0, cfg_v_o=0, x=y=0, count_o=0,
//   checksum_o=0. Reset wins over every other input, same cycle.
//  All outputs registered. States: IDLE, SEND, DONE.
//  IDLE:
//   - start_i=1: go to SEND at (0,0), clear count/checksum; busy_o=1 next cycle.
//   - count_o/checksum_o keep the last scan's values until the next start.
//  SEND:
//   - Entry non-skipped: cfg_v_o=1. y/x/data held stable until cfg_v_o&cfg_ready_i.
//   - Valid never drops before the handshake.
//   - On transfer: count_o+=1, checksum_o^=data, advance the coordinate.
//   - Skipped entry (SKIP_ZERO_P=1, value 0): costs one cycle with cfg_v_o=0;
//     advance without count/checksum update.
//   - Advance: x+1; at x==N_X_P-1 set x=0 and y+1.
//   - Leaving (N_Y_P-1,N_X_P-1), transferred or skipped: go to DONE, no wrap;
//     cfg_v_o=0 next cycle.
//  DONE: one cycle, done_o=1, busy_o=0, then IDLE. start_i in DONE is ignored.
//  start_i while busy: ignored, no restart.
//  Latency, ready=1, no skips:
//   - start cycle 0; words on cycles 1..N (N=N_X_P*N_Y_P).
//   - done_o on cycle N+1; start accepted again from cycle N+2.
//  Reset mid-scan: scan abandoned, cfg_v_o=0 next cycle, partial count lost.
//  1x1 grid: single word, then DONE. With SKIP_ZERO_P and all entries zero:
//   N cycles with no valid, then done_o, count_o=0, checksum_o=0.
//
// STRUCTURE
//  Package tile_cfg_pkg:
//   - state enum {IDLE,SEND,DONE}
//   - width helper function max1_clog2()
//  Sub-module grid_coord_counter: x/y row-major counter.
//   - Inputs: clear and advance.
//   - Outputs: x, y, last flag, no wrap past last.
//  Top holds FSM, ROM lookup of TWODIM_P, count and checksum regs.
//
// TESTING
//  1. 2x2, TWODIM_P='{'{1,2},'{3,4}}, ready=1, start@0:
//     - (y,x,data)=(0,0,1),(0,1,2),(1,0,3),(1,1,4) on cycles 1-4.
//     - done_o@5; count_o=4, checksum_o=4.
//  2. Same grid, cfg_ready_i=0 cycles 2-4:
//     - cfg_v_o stays 1 with (0,1,2) held through cycle 4.
//     - Accepted cycle 5; done_o@8.
//  3. SKIP_ZERO_P=1, '{'{0,5},'{0,0}}:
//     - Exactly one transfer, (0,1,5).
//     - done_o@5, count_o=1, checksum_o=5.
//  4. start_i held every cycle through a scan:
//     - No restart mid-scan and none in the DONE cycle.
//     - Next start after IDLE repeats sequence 1 exactly.
//  5. reset at cycle 3 of sequence 1:
//     - cfg_v_o=0, busy_o=0, count_o=0 next cycle.
//     - New start begins at (0,0) with data 1.
//  6. Defaults (4x4 zeros, SKIP_ZERO_P=0):
//     - 16 transfers of 0, coords wrap x 3->0 per row.
//     - count_o=16, checksum_o=0, done_o@17.

Source files
------------

// File: rtl/tile_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tile_cfg_pkg
// Brief   : Shared types and width helpers for the tile config streamer.
// Revision: 1.0
// ============================================================================
package tile_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A 1-entry dimension still needs a 1-bit coordinate port.
  function automatic int max1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/grid_coord_counter.sv
`default_nettype none
// ============================================================================
// Module  : grid_coord_counter
// Brief   : Row-major (y,x) walker with clear/advance; holds at the last tile.
// Revision: 1.0
// ============================================================================
module grid_coord_counter
  import tile_cfg_pkg::*;
#(
  parameter int N_X_P = 4,
  parameter int N_Y_P = 4,
  localparam int X_W = max1_clog2(N_X_P),
  localparam int Y_W = max1_clog2(N_Y_P)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_clear,
  input  logic           i_adv,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic [X_W-1:0] o_x_nxt,
  output logic [Y_W-1:0] o_y_nxt,
  output logic           o_last
);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [X_W-1:0] w_x_nxt;
  logic [Y_W-1:0] w_y_nxt;
  logic           w_x_end;
  logic           w_y_end;

  assign w_x_end = (r_x == X_W'(N_X_P - 1));
  assign w_y_end = (r_y == Y_W'(N_Y_P - 1));

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (i_clear) begin
      w_x_nxt = '0;
      w_y_nxt = '0;
    end else if (i_adv && !(w_x_end && w_y_end)) begin
      if (w_x_end) begin
        w_x_nxt = '0;
        w_y_nxt = r_y + 1'b1;
      end else begin
        w_x_nxt = r_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
    end
  end

  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_x_nxt = w_x_nxt;
  assign o_y_nxt = w_y_nxt;
  assign o_last  = w_x_end && w_y_end;

endmodule
`default_nettype wire

// File: rtl/tile_param_cfg_streamer.sv
`default_nettype none
// ============================================================================
// Module  : tile_param_cfg_streamer
// Brief   : Streams a 2-D parameter table row-major over valid/ready with
//           busy/done, transfer count and XOR checksum reporting.
// Revision: 1.0
// ============================================================================
module tile_param_cfg_streamer
  import tile_cfg_pkg::*;
#(
  parameter int N_X_P       = 4,
  parameter int N_Y_P       = 4,
  parameter int DATA_W_P    = 32,
  parameter int SKIP_ZERO_P = 0,
  parameter int TWODIM_P [0:N_Y_P-1][0:N_X_P-1] = '{default: 0},
  localparam int X_W   = max1_clog2(N_X_P),
  localparam int Y_W   = max1_clog2(N_Y_P),
  localparam int CNT_W = $clog2(N_X_P * N_Y_P + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                cfg_v_o,
  input  logic                cfg_ready_i,
  output logic [Y_W-1:0]      cfg_y_o,
  output logic [X_W-1:0]      cfg_x_o,
  output logic [DATA_W_P-1:0] cfg_data_o,
  output logic [CNT_W-1:0]    count_o,
  output logic [DATA_W_P-1:0] checksum_o
);

  function automatic logic [DATA_W_P-1:0] f_rom(input logic [Y_W-1:0] y,
                                                input logic [X_W-1:0] x);
    return DATA_W_P'(TWODIM_P[y][x]);
  endfunction

  function automatic logic f_skip(input logic [DATA_W_P-1:0] d);
    return (SKIP_ZERO_P != 0) && (d == '0);
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_clear;
  logic                  w_step;
  logic                  w_xfer;
  logic                  w_last;
  logic [X_W-1:0]        w_x;
  logic [Y_W-1:0]        w_y;
  logic [X_W-1:0]        w_x_nxt;
  logic [Y_W-1:0]        w_y_nxt;
  logic [DATA_W_P-1:0]   w_data_nxt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_valid;
  logic [DATA_W_P-1:0]   r_data;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W_P-1:0]   r_sum;

  grid_coord_counter #(
    .N_X_P (N_X_P),
    .N_Y_P (N_Y_P)
  ) u_coord (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_adv   (w_step),
    .o_x     (w_x),
    .o_y     (w_y),
    .o_x_nxt (w_x_nxt),
    .o_y_nxt (w_y_nxt),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // In SEND an entry with valid low is a skipped one and always steps.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_step      = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_xfer = r_valid && cfg_ready_i;
        w_step = w_xfer || !r_valid;
        if (w_step && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Word/valid are looked up from the coordinate the counter moves to.
  assign w_data_nxt = f_rom(w_y_nxt, w_x_nxt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else begin
      r_busy  <= (w_state_nxt == ST_SEND);
      r_done  <= (w_state_nxt == ST_DONE);
      r_valid <= (w_state_nxt == ST_SEND) && !f_skip(w_data_nxt);
      r_data  <= w_data_nxt;
      if (w_clear) begin
        r_cnt <= '0;
        r_sum <= '0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 1'b1;
        r_sum <= r_sum ^ r_data;
      end
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign cfg_v_o    = r_valid;
  assign cfg_y_o    = w_y;
  assign cfg_x_o    = w_x;
  assign cfg_data_o = r_data;
  assign count_o    = r_cnt;
  assign checksum_o = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_tile_param_cfg_streamer.sv
`default_nettype none
// ============================================================================
// Module  : tb_tile_param_cfg_streamer
// Brief   : Four streamer configurations driven together, compared each cycle
//           against a linear-index reference model.
// Revision: 1.0
// ============================================================================
module tb_tile_param_cfg_streamer;

  localparam int NK = 4;
  localparam int G0 [0:1][0:1] = '{'{1, 2}, '{3, 4}};
  localparam int G1 [0:2][0:2] = '{'{0, 5, 0}, '{300, 0, 7}, '{256, 9, 0}};
  localparam int G2 [0:1][0:2] = '{'{0, 7, 0}, '{65537, 0, 2}};

  logic clk = 1'b0;
  logic reset;
  logic start_i;
  logic cfg_ready_i;
  always #5 clk = ~clk;

  logic        b0, d0, v0, b1, d1, v1, b2, d2, v2, b3, d3, v3;
  logic [0:0]  y0, x0, y2;
  logic [1:0]  y1, x1, x2, y3, x3;
  logic [31:0] dat0, s0, dat3, s3;
  logic [7:0]  dat1, s1;
  logic [15:0] dat2, s2;
  logic [2:0]  c0, c2;
  logic [3:0]  c1;
  logic [4:0]  c3;

  tile_param_cfg_streamer #(.N_X_P(2), .N_Y_P(2), .DATA_W_P(32), .SKIP_ZERO_P(0), .TWODIM_P(G0)) u_dut0 (
    .clk(clk), .reset(reset), .start_i(start_i), .busy_o(b0), .done_o(d0), .cfg_v_o(v0),
    .cfg_ready_i(cfg_ready_i), .cfg_y_o(y0), .cfg_x_o(x0), .cfg_data_o(dat0), .count_o(c0), .checksum_o(s0));
  tile_param_cfg_streamer #(.N_X_P(3), .N_Y_P(3), .DATA_W_P(8), .SKIP_ZERO_P(1), .TWODIM_P(G1)) u_dut1 (
    .clk(clk), .reset(reset), .start_i(start_i), .busy_o(b1), .done_o(d1), .cfg_v_o(v1),
    .cfg_ready_i(cfg_ready_i), .cfg_y_o(y1), .cfg_x_o(x1), .cfg_data_o(dat1), .count_o(c1), .checksum_o(s1));
  tile_param_cfg_streamer #(.N_X_P(3), .N_Y_P(2), .DATA_W_P(16), .SKIP_ZERO_P(0), .TWODIM_P(G2)) u_dut2 (
    .clk(clk), .reset(reset), .start_i(start_i), .busy_o(b2), .done_o(d2), .cfg_v_o(v2),
    .cfg_ready_i(cfg_ready_i), .cfg_y_o(y2), .cfg_x_o(x2), .cfg_data_o(dat2), .count_o(c2), .checksum_o(s2));
  tile_param_cfg_streamer u_dut3 (
    .clk(clk), .reset(reset), .start_i(start_i), .busy_o(b3), .done_o(d3), .cfg_v_o(v3),
    .cfg_ready_i(cfg_ready_i), .cfg_y_o(y3), .cfg_x_o(x3), .cfg_data_o(dat3), .count_o(c3), .checksum_o(s3));

  logic        ob_busy [NK];
  logic        ob_done [NK];
  logic        ob_v    [NK];
  logic [31:0] ob_y    [NK];
  logic [31:0] ob_x    [NK];
  logic [31:0] ob_data [NK];
  logic [31:0] ob_cnt  [NK];
  logic [31:0] ob_sum  [NK];

  always_comb begin
    ob_busy = '{b0, b1, b2, b3};
    ob_done = '{d0, d1, d2, d3};
    ob_v    = '{v0, v1, v2, v3};
    ob_y    = '{32'(y0), 32'(y1), 32'(y2), 32'(y3)};
    ob_x    = '{32'(x0), 32'(x1), 32'(x2), 32'(x3)};
    ob_data = '{dat0, 32'(dat1), 32'(dat2), dat3};
    ob_cnt  = '{32'(c0), 32'(c1), 32'(c2), 32'(c3)};
    ob_sum  = '{s0, 32'(s1), 32'(s2), s3};
  end

  int nx [NK] = '{2, 3, 3, 4};
  int ny [NK] = '{2, 3, 2, 4};
  int dw [NK] = '{32, 8, 16, 32};
  int skp[NK] = '{0, 1, 0, 0};
  int grid [NK][4][4];

  bit          m_busy [NK];
  bit          m_done [NK];
  int          m_idx  [NK];
  int          m_cnt  [NK];
  logic [31:0] m_sum  [NK];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] got=0x%0h want=0x%0h at %0t", tag, k, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ent(input int k, input int i);
    logic [31:0] v;
    v = grid[k][i / nx[k]][i % nx[k]];
    if (dw[k] < 32) v = v & ((32'd1 << dw[k]) - 32'd1);
    return v;
  endfunction

  function automatic bit skipped(input int k, input int i);
    return (skp[k] != 0) && (ent(k, i) == 32'd0);
  endfunction

  task automatic model_edge();
    logic [31:0] e;
    for (int k = 0; k < NK; k++) begin
      if (reset) begin
        m_busy[k] = 0; m_done[k] = 0; m_idx[k] = 0; m_cnt[k] = 0; m_sum[k] = '0;
      end else if (m_done[k]) begin
        m_done[k] = 0;
      end else if (!m_busy[k]) begin
        if (start_i) begin
          m_busy[k] = 1; m_idx[k] = 0; m_cnt[k] = 0; m_sum[k] = '0;
        end
      end else if (skipped(k, m_idx[k]) || cfg_ready_i) begin
        e = ent(k, m_idx[k]);
        if (!skipped(k, m_idx[k])) begin
          m_cnt[k]++;
          m_sum[k] ^= e;
        end
        if (m_idx[k] == nx[k] * ny[k] - 1) begin
          m_busy[k] = 0;
          m_done[k] = 1;
        end else begin
          m_idx[k]++;
        end
      end
    end
  endtask

  task automatic check_all();
    bit ev;
    for (int k = 0; k < NK; k++) begin
      ev = m_busy[k] && !skipped(k, m_idx[k]);
      chk("busy", k, 32'(ob_busy[k]), 32'(m_busy[k]));
      chk("done", k, 32'(ob_done[k]), 32'(m_done[k]));
      chk("valid", k, 32'(ob_v[k]), 32'(ev));
      chk("count", k, ob_cnt[k], 32'(m_cnt[k]));
      chk("checksum", k, ob_sum[k], m_sum[k]);
      if (ev) begin
        chk("y", k, ob_y[k], 32'(m_idx[k] / nx[k]));
        chk("x", k, ob_x[k], 32'(m_idx[k] % nx[k]));
        chk("data", k, ob_data[k], ent(k, m_idx[k]));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    grid = '{default: 0};
    for (int y = 0; y < 2; y++) for (int x = 0; x < 2; x++) grid[0][y][x] = G0[y][x];
    for (int y = 0; y < 3; y++) for (int x = 0; x < 3; x++) grid[1][y][x] = G1[y][x];
    for (int y = 0; y < 2; y++) for (int x = 0; x < 3; x++) grid[2][y][x] = G2[y][x];

    reset = 1'b1; start_i = 1'b0; cfg_ready_i = 1'b1;
    repeat (3) step();
    for (int k = 0; k < NK; k++) begin
      chk("rst_y", k, ob_y[k], 32'd0);
      chk("rst_x", k, ob_x[k], 32'd0);
    end
    reset = 1'b0;
    step();

    // One clean scan with ready high, then the end-of-scan totals.
    start_i = 1'b1; step(); start_i = 1'b0;
    repeat (20) step();
    chk("tot_cnt", 0, ob_cnt[0], 32'd4);
    chk("tot_sum", 0, ob_sum[0], 32'd4);
    chk("tot_cnt", 1, ob_cnt[1], 32'd4);
    chk("tot_sum", 1, ob_sum[1], 32'd39);
    chk("tot_cnt", 2, ob_cnt[2], 32'd6);
    chk("tot_sum", 2, ob_sum[2], 32'd4);
    chk("tot_cnt", 3, ob_cnt[3], 32'd16);
    chk("tot_sum", 3, ob_sum[3], 32'd0);

    // Back-pressure on the second word.
    start_i = 1'b1; step(); start_i = 1'b0; step();
    cfg_ready_i = 1'b0; repeat (3) step();
    cfg_ready_i = 1'b1; repeat (20) step();

    // Start held high across scans and DONE cycles.
    start_i = 1'b1; repeat (45) step();
    start_i = 1'b0; repeat (20) step();

    // Reset in the middle of a scan, then a fresh scan.
    start_i = 1'b1; step(); start_i = 1'b0; repeat (2) step();
    reset = 1'b1; step(); reset = 1'b0; step();
    start_i = 1'b1; step(); start_i = 1'b0; repeat (20) step();

    repeat (3000) begin
      start_i     = ($urandom_range(0, 7) == 0);
      cfg_ready_i = ($urandom_range(0, 3) != 0);
      reset       = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; start_i = 1'b0; cfg_ready_i = 1'b1;
    repeat (30) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
